score_display: RTL
==================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits, legal range 1..8.
REQ-002 Parameter BIN_W, default 14: width of the binary input value.
REQ-003 Parameter SCAN_W, default 16: prescaler width; each digit is shown for 2^SCAN_W clk cycles.
REQ-004 Parameter BLINK_W, default 26: blink counter width; the blink phase is the counter MSB.
REQ-005 clk  in  1  system clock (100 MHz); the block SHALL use this single clock only.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 value  in  BIN_W  unsigned binary number to display.
REQ-008 load  in  1  one-cycle request to capture value and start conversion.
REQ-009 blank_lz  in  1  1 = blank leading zeros.
REQ-010 blink_en  in  1  1 = flash the whole display at the blink rate.
REQ-011 dp_mask  in  NUM_DIGITS  active-high decimal point enable per digit; bit 0 = rightmost digit.
REQ-012 busy  out  1  high while a conversion is in progress.
REQ-013 overflow  out  1  high while the displayed value exceeds 10^NUM_DIGITS-1.
REQ-014 seg  out  7  segments {g,f,e,d,c,b,a}, active low.
REQ-015 dp  out  1  decimal point, active low.
REQ-016 an  out  NUM_DIGITS  digit enables, active low; bit 0 = rightmost digit.

Function
REQ-017 Conversion SHALL be sequential shift-add-3 (double dabble), one bit per cycle, into a 4*NUM_DIGITS-bit BCD shadow register.
REQ-018 A load while busy=0 SHALL capture value; busy SHALL rise the next cycle and stay high for exactly BIN_W cycles.
REQ-019 A load while busy=1 SHALL be ignored, with no effect on the conversion in progress.
REQ-020 On the cycle busy falls, the shadow BCD digits SHALL be copied atomically to the display digit registers, and overflow SHALL update at the same time.
REQ-021 overflow SHALL be 1 iff the captured value > 10^NUM_DIGITS-1; while overflow=1, every digit SHALL show a dash (seg=0111111) and blanking SHALL not apply.
REQ-022 Scan prescaler SHALL count up every cycle; at terminal count 2^SCAN_W-1 the digit index SHALL advance and wrap from NUM_DIGITS-1 to 0, including for non-power-of-2 NUM_DIGITS.
REQ-023 an SHALL have exactly one bit low (the current index), except when blanked by blink or reset.
REQ-024 Digit encoding SHALL be the standard active-low pattern table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 With blank_lz=1, any digit above the most significant nonzero digit SHALL drive seg=1111111; digit 0 SHALL never be blanked.
REQ-026 dp SHALL equal ~dp_mask[index].
REQ-027 With blink_en=1 and blink phase=1, an SHALL be all ones; the blink counter SHALL run freely regardless of blink_en.
REQ-028 seg, dp and an SHALL be registered outputs, lagging the index by exactly one cycle.
REQ-029 The display SHALL continue showing the previous digits, glitch-free, throughout a conversion.

Reset
REQ-030 While rst=1: prescaler, blink counter, index, BCD shadow and display digits SHALL be 0; busy=0; overflow=0; an all ones; seg=1111111; dp=1.
REQ-031 A reset asserted mid-conversion SHALL abort the conversion, leave no partial update, and drop busy on the next cycle.
REQ-032 After reset release, the first registered output SHALL show digit 0 with value 0 (an[0]=0, seg=1000000).

Verification
REQ-033 NUM_DIGITS=4, SCAN_W=2: load value=1234 -> busy high 14 cycles; then digits 4,3,2,1 appear on an=1110,1101,1011,0111, each held 4 cycles.
REQ-034 load value=7, blank_lz=1 -> digits 3..1 seg=1111111, digit 0 seg=1111000; with blank_lz=0 -> digits 3..1 seg=1000000.
REQ-035 load value=10000 (BIN_W=14) -> overflow=1, all digits seg=0111111; then load 9999 -> overflow=0, all digits seg=0010000.
REQ-036 load 42, then load 99 three cycles later -> second load ignored, display shows 0042; assert rst at cycle 5 of a conversion -> busy=0, display 0000.
REQ-037 NUM_DIGITS=3: index wraps 2->0, and an never equals all-low or shows two low bits; blink_en=1 with BLINK_W=4 -> an=111 for 8 of every 16 cycles.
REQ-038 dp_mask=0100 -> dp=0 only while an=1011.

Source files
------------

// File: rtl/score_display.sv
// Purpose: multiplexed 7-segment driver with sequential binary-to-BCD conversion, zero blanking, overflow dashes, blink and decimal points.
// Latency: BIN_W cycles from an accepted load to the display digit update; seg/dp/an lag the scan index by one cycle.
// Backpressure: busy is high while converting; a load that arrives while busy is dropped.
module score_display #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter int SCAN_W     = 16,
    parameter int BLINK_W    = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Largest value representable in NUM_DIGITS decimal digits.
    function automatic logic [63:0] max_disp(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction
    localparam logic [63:0] MAX_VAL = max_disp(NUM_DIGITS);

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIN_W-1:0]      shift_q, shift_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]      disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic [SCAN_W-1:0]     presc_q, presc_d;
    logic [BLINK_W-1:0]    blink_q, blink_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [BCD_W-1:0]      adj;
    logic [BCD_W-1:0]      step;
    logic [3:0]            digit;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  above_zero;
    logic [3:0]            cur;

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next binary MSB.
    always_comb begin
        adj   = '0;
        digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = bcd_q[4*i +: 4];
            if (digit >= 4'd5) digit = digit + 4'd3;
            adj[4*i +: 4] = digit;
        end
        step = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
    end

    // Conversion sequencer; the shadow only reaches the display on the final step, so no partial value is ever shown.
    always_comb begin
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        if (busy_q) begin
            bcd_d   = step;
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
                busy_d = 1'b0;
                disp_d = step;
                ovf_d  = ovf_pend_q;
            end
        end else if (load) begin
            busy_d     = 1'b1;
            shift_d    = value;
            bcd_d      = '0;
            cnt_d      = '0;
            // Overflow is judged on the full binary value; the BCD shadow drops high digits.
            ovf_pend_d = (64'(value) > MAX_VAL);
        end
    end

    // Digit scanning, blink phase and the registered segment/anode/dp outputs.
    always_comb begin
        presc_d = presc_q + SCAN_W'(1);
        blink_d = blink_q + BLINK_W'(1);
        idx_d   = idx_q;
        if (presc_q == '1) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        above_zero = 1'b1;
        blank_vec  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            above_zero   = above_zero & (disp_q[4*i +: 4] == 4'd0);
            blank_vec[i] = above_zero;
        end

        cur = disp_q[4*idx_q +: 4];
        if (ovf_q)                           seg_d = 7'b0111111;
        else if (blank_lz && blank_vec[idx_q]) seg_d = 7'b1111111;
        else                                 seg_d = decode(cur);

        dp_d = ~dp_mask[idx_q];
        an_d = ~(NUM_DIGITS'(1) << idx_q);
        if (blink_en && blink_q[BLINK_W-1]) an_d = '1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            blink_q    <= '0;
            idx_q      <= '0;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            blink_q    <= blink_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
endmodule
